// File: rtl/uart_rx_if.sv
// Byte-stream side of the UART receiver: valid/ready data handshake plus
// the frame-error and overrun status pulses.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  // Receiver side drives data and status, consumer returns ready.
  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, start-bit qualification at half-bit,
// mid-bit sampling of 8 data bits LSB first, stop-bit check, and a single
// output register with valid/ready handshake, frame-error and overrun pulses.
// CLKS_PER_BIT (CLK_FREQ/BAUD_RATE) must be at least 4.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 27000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rx,
  uart_rx_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic          rx_meta, rxs;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Decode strobes from the FSM
  logic cnt_clr;
  logic idx_clr;
  logic sample_data;
  logic byte_done;
  logic stop_bad;

  // Bring the asynchronous line into the clk domain; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and strobe decode; the bit counter is cleared on every
  // transition so each state starts counting from zero.
  always_comb begin
    state_n     = state;
    cnt_clr     = 1'b0;
    idx_clr     = 1'b0;
    sample_data = 1'b0;
    byte_done   = 1'b0;
    stop_bad    = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rxs) begin
          state_n = START;
        end
      end
      START: begin
        if (bit_cnt == HALF_LAST) begin
          cnt_clr = 1'b1;
          idx_clr = 1'b1;
          // Line back high at mid start bit: a glitch, not a frame.
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          cnt_clr     = 1'b1;
          sample_data = 1'b1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end
        end
      end
      STOP: begin
        if (bit_cnt == BIT_LAST) begin
          cnt_clr = 1'b1;
          if (rxs) begin
            byte_done = 1'b1;
            state_n   = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_n  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_clr = 1'b1;
        if (rxs) begin
          state_n = IDLE;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  // Bit-period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (cnt_clr) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Data-bit index and byte assembly, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (idx_clr) begin
        bit_idx <= '0;
      end else if (sample_data) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (sample_data) begin
        shreg[bit_idx] <= rxs;
      end
    end
  end

  // Output register and handshake. A byte completing in the same cycle as
  // an accept replaces the old one with valid kept high; completing while
  // the old byte is still pending drops the new byte and flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.frame_err <= stop_bad;
      bus.overrun   <= 1'b0;
      if (byte_done) begin
        if (!bus.rx_valid || bus.rx_ready) begin
          bus.rx_data  <= shreg;
          bus.rx_valid <= 1'b1;
        end else begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;

  uart_rx_if bus();

  uart_rx #(
    .CLK_FREQ  (1600),
    .BAUD_RATE (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
    end
  endtask

  // Observer: records accepted bytes and counts status activity.
  logic [7:0]  got_q[$];
  int unsigned vcyc = 0, rises = 0, fe_cyc = 0, ov_cyc = 0, stab_err = 0, last_rise = 0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [7:0]  pd = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_valid) vcyc <= vcyc + 1;
      if (bus.rx_valid && !pv) begin
        rises     <= rises + 1;
        last_rise <= cyc;
      end
      if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
      if (bus.frame_err) fe_cyc <= fe_cyc + 1;
      if (bus.overrun) ov_cyc <= ov_cyc + 1;
      if (pv && !pr && bus.rx_valid && bus.rx_data !== pd) stab_err <= stab_err + 1;
    end
    pv <= bus.rx_valid;
    pr <= bus.rx_ready;
    pd <= bus.rx_data;
  end

  // Advance n posedges, then settle 1 time unit past the edge.
  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame onto the line; stop level selectable.
  int unsigned frame_start;
  task automatic send_frame(input logic [7:0] b, input logic stopv);
    frame_start = cyc;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stopv;
    tick(CPB);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] e);
    int unsigned n;
    n = 0;
    while (got_q.size() == 0 && n < 400) begin
      tick(1);
      n++;
    end
    if (got_q.size() == 0) chk({tag, "_present"}, got_q.size(), 1);
    else chk(tag, got_q.pop_front(), e);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data"},  bus.rx_data,   8'h00);
    chk({tag, "_valid"}, bus.rx_valid,  1'b0);
    chk({tag, "_ferr"},  bus.frame_err, 1'b0);
    chk({tag, "_ovr"},   bus.overrun,   1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned r0, v0, f0, o0, lat;
    logic [7:0]  exp_q[$];
    int unsigned fe_exp;

    rx           = 1'b1;
    bus.rx_ready = 1'b0;
    rst_n        = 1'b0;
    tick(5);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick(20);

    // 1: reset asserted part-way through a frame, then idle line.
    rx = 1'b0; tick(CPB);
    rx = 1'b1; tick(CPB);
    rx = 1'b0; tick(CPB + 3);
    rst_n = 1'b0;
    tick(2);
    chk_outputs_zero("midreset");
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    r0 = rises; f0 = fe_cyc;
    tick(500);
    chk("idle_rises", rises - r0, 0);
    chk("idle_ferr",  fe_cyc - f0, 0);
    chk_outputs_zero("idle");

    // 2: hold a byte unaccepted, then overrun.
    send_frame(8'h55, 1'b1);
    tick(5);
    chk("hold_valid", bus.rx_valid, 1'b1);
    chk("hold_data",  bus.rx_data,  8'h55);
    o0 = ov_cyc;
    send_frame(8'hA5, 1'b1);
    tick(5);
    chk("ovr_pulse",  ov_cyc - o0, 1);
    chk("ovr_data",   bus.rx_data,  8'h55);
    chk("ovr_valid",  bus.rx_valid, 1'b1);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    expect_byte("ovr_accept", 8'h55);
    tick(2);
    chk("ovr_cleared", bus.rx_valid, 1'b0);

    // 3: all-ones byte with ready high; one-cycle valid and latency.
    bus.rx_ready = 1'b1;
    r0 = rises; v0 = vcyc;
    send_frame(8'hFF, 1'b1);
    tick(10);
    chk("ff_rises", rises - r0, 1);
    chk("ff_vcyc",  vcyc - v0, 1);
    lat = last_rise - frame_start;
    chk("ff_latency", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
    expect_byte("ff_data", 8'hFF);

    // 4: short low glitch is ignored.
    r0 = rises; f0 = fe_cyc;
    rx = 1'b0; tick(4);
    rx = 1'b1; tick(60);
    chk("glitch_rises", rises - r0, 0);
    chk("glitch_ferr",  fe_cyc - f0, 0);
    send_frame(8'h3C, 1'b1);
    tick(5);
    expect_byte("glitch_next", 8'h3C);

    // 5: framing error followed by held-low line.
    r0 = rises; f0 = fe_cyc;
    send_frame(8'h81, 1'b0);
    rx = 1'b0; tick(100);
    rx = 1'b1; tick(2 * CPB);
    chk("ferr_pulse", fe_cyc - f0, 1);
    chk("ferr_rises", rises - r0, 0);
    send_frame(8'h12, 1'b1);
    tick(5);
    expect_byte("ferr_next", 8'h12);

    // 6: back-to-back frames, then accept coinciding with next load.
    r0 = rises; o0 = ov_cyc;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    tick(5);
    expect_byte("b2b_0", 8'h00);
    expect_byte("b2b_1", 8'hFF);
    expect_byte("b2b_2", 8'h5A);
    chk("b2b_rises", rises - r0, 3);

    bus.rx_ready = 1'b0;
    send_frame(8'h6B, 1'b1);
    tick(3);
    r0 = rises;
    fork
      send_frame(8'hC4, 1'b1);
      begin
        tick(154);
        bus.rx_ready = 1'b1;
      end
    join
    tick(5);
    expect_byte("same_old", 8'h6B);
    expect_byte("same_new", 8'hC4);
    chk("same_rises", rises - r0, 0);
    chk("b2b_ovr",    ov_cyc - o0, 0);

    // Random traffic against a frame-level model.
    bus.rx_ready = 1'b1;
    fe_exp = 0;
    f0 = fe_cyc; o0 = ov_cyc;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] b;
      logic       bad;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, !bad);
      if (bad) begin
        fe_exp++;
        rx = 1'b0;
        tick($urandom_range(0, 30));
        rx = 1'b1;
        tick(CPB);
      end else begin
        exp_q.push_back(b);
        tick($urandom_range(0, 20));
      end
    end
    tick(20);
    chk("rnd_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0) expect_byte("rnd_byte", exp_q.pop_front());
    chk("rnd_ferr", fe_cyc - f0, fe_exp);
    chk("rnd_ovr",  ov_cyc - o0, 0);
    chk("data_stable", stab_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
